fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter DEPTH, default 2, fetch buffer entries; only 2 is supported.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 imem_addr  output  32  instruction memory byte address.
REQ-006 imem_data  input  32  instruction word, combinational from imem_addr within the same cycle.
REQ-007 redirect_valid  input  1  branch/jump resolved taken; redirect this cycle.
REQ-008 redirect_pc  input  32  redirect target address.
REQ-009 dec_ready  input  1  decode accepts the head instruction this cycle.
REQ-010 dec_valid  output  1  head instruction valid toward decode.
REQ-011 dec_instr  output  32  head instruction word.
REQ-012 dec_pc  output  32  address of the head instruction.

Function
REQ-013 imem_addr SHALL equal the fetch PC register pc_q; no combinational path from any input to imem_addr.
REQ-014 The buffer SHALL be a 2-entry FIFO of {pc, instr} with an occupancy count of 0..2.
REQ-015 Dequeue SHALL occur when dec_valid && dec_ready && !redirect_valid.
REQ-016 Enqueue SHALL occur when !redirect_valid && (count<2 || dequeue): store {pc_q, imem_data}, pc_q <= pc_q+4.
REQ-017 PC increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000).
REQ-018 Simultaneous enqueue and dequeue SHALL leave count unchanged and preserve FIFO order, including at count==2.
REQ-019 With count==2 and no dequeue, pc_q and buffer SHALL hold; imem_addr stays stable.
REQ-020 redirect_valid SHALL, in that cycle, set pc_q <= {redirect_pc[31:2],2'b00}, set count to 0, suppress enqueue, and suppress dequeue regardless of dec_ready.
REQ-021 dec_valid SHALL be 0 while redirect_valid is 1 (combinational gating) and while count==0.
REQ-022 dec_valid SHALL otherwise equal (count!=0); dec_instr/dec_pc SHALL present the head entry.
REQ-023 When count==0, dec_instr SHALL be 32'h0000_0013 (NOP) and dec_pc 32'h0.
REQ-024 Latency: the word at pc_q SHALL appear on dec_* no earlier than the cycle after enqueue; sustained throughput 1 instr/cycle with dec_ready held high.
REQ-025 A redirect SHALL produce its first dec_valid two cycles after the redirect cycle (fetch at target next cycle, valid the following).

Reset
REQ-026 While rst_n==0 at posedge clk: pc_q <= RESET_PC, count <= 0, head/tail pointers <= 0.
REQ-027 Reset SHALL dominate redirect_valid and any handshake in the same cycle.
REQ-028 Outputs after reset: imem_addr=RESET_PC, dec_valid=0, dec_instr=32'h0000_0013, dec_pc=0.
REQ-029 Reset mid-operation SHALL discard buffered entries with no dec_valid pulse in the following cycle.

Structure
REQ-030 Shared package SHALL hold XLEN=32, NOP_INSTR=32'h0000_0013, default RESET_PC, and the {pc,instr} fetch-entry typedef.
REQ-031 The FIFO SHALL be one sub-module, fetch_fifo (push, pop, flush, count, head entry); PC logic stays in fetch_stage.

Verification
REQ-032 Reset, imem word(i)=0x100+i, dec_ready=1 -> dec_pc 0,4,8,... with dec_valid=1 every cycle from cycle 2 after reset release.
REQ-033 dec_ready=0 for 5 cycles -> count saturates at 2, imem_addr frozen at 0x8, entries 0x0,0x4 delivered in order once dec_ready=1.
REQ-034 redirect_valid=1, redirect_pc=0x40 with count==2 -> dec_valid=0 that cycle, imem_addr=0x40 next cycle, dec_pc=0x40 two cycles later, no stale 0x8/0xC delivered.
REQ-035 redirect_pc=0x43 -> imem_addr=0x40.
REQ-036 RESET_PC=32'hFFFF_FFF8 -> dec_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 rst_n=0 asserted one cycle while count==2 and redirect_valid=1 -> imem_addr=RESET_PC, dec_valid=0 next cycle.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared widths, constants and the fetch-entry type
package fetch_stage_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: two-entry in-order buffer of fetched {pc, instr} pairs
module fetch_fifo import fetch_stage_pkg::*; (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [1:0]   count,
  output fetch_entry_t head
);
  fetch_entry_t mem [2];
  logic hp, tp;
  always_ff @(posedge clk)
    if (!rst_n || flush) begin
      count <= '0;
      hp <= 1'b0;
      tp <= 1'b0;
    end else begin
      if (push) begin
        mem[tp] <= din;
        tp <= ~tp;
      end
      if (pop) hp <= ~hp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  assign head = mem[hp];
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: sequential PC fetch into a two-entry buffer with redirect and decode handshake
module fetch_stage import fetch_stage_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            dec_ready,
  output logic            dec_valid,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc
);
  logic [XLEN-1:0] pc_q;
  logic [1:0] count;
  logic deq, enq, has;
  fetch_entry_t head;
  assign has = count != 2'd0;
  assign deq = has && dec_ready && !redirect_valid;
  assign enq = !redirect_valid && (count != 2'(DEPTH) || deq);
  assign imem_addr = pc_q;
  assign dec_valid = has && !redirect_valid;
  assign dec_instr = has ? head.instr : NOP_INSTR;
  assign dec_pc = has ? head.pc : '0;
  always_ff @(posedge clk)
    if (!rst_n) pc_q <= RESET_PC;
    else if (redirect_valid) pc_q <= redirect_pc & ~32'h3;
    else if (enq) pc_q <= pc_q + 32'd4;
  fetch_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (enq),
    .pop   (deq),
    .flush (redirect_valid),
    .din   ('{pc: pc_q, instr: imem_data}),
    .count (count),
    .head  (head)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random checks of fetch_stage against a queue-based model
module tb_fetch_stage;
  localparam logic [31:0] R2 = 32'hFFFF_FFF8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic dec_ready = 1'b0;
  logic [31:0] imem_addr, imem_data, dec_instr, dec_pc;
  logic dec_valid;
  logic [31:0] imem_addr2, imem_data2, dec_instr2, dec_pc2;
  logic dec_valid2;
  int total = 0;
  int fails = 0;
  logic [31:0] mpc;
  logic [31:0] qpc[$];
  logic [31:0] qins[$];
  logic armed = 1'b0;
  logic clean2 = 1'b0;
  int since = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h100 + (a >> 2);
  endfunction

  assign imem_data = word(imem_addr);
  assign imem_data2 = word(imem_addr2);

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .dec_ready(dec_ready),
    .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc)
  );

  fetch_stage #(.RESET_PC(R2)) dut2 (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr2), .imem_data(imem_data2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .dec_ready(dec_ready),
    .dec_valid(dec_valid2), .dec_instr(dec_instr2), .dec_pc(dec_pc2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic rv, input logic [31:0] rp, input logic rd);
    logic deq, enq;
    @(negedge clk);
    rst_n = r;
    redirect_valid = rv;
    redirect_pc = rp;
    dec_ready = rd;
    #1;
    if (armed) begin
      chk("imem_addr", imem_addr, mpc);
      chk("dec_valid", {31'd0, dec_valid}, {31'd0, !rv && qpc.size() != 0});
      chk("dec_pc", dec_pc, qpc.size() != 0 ? qpc[0] : 32'h0);
      chk("dec_instr", dec_instr, qins.size() != 0 ? qins[0] : 32'h0000_0013);
      if (clean2 && since >= 1 && since <= 6 && !rv) begin
        chk("imem_addr2", imem_addr2, R2 + 32'(4 * (since - 1)));
        chk("dec_valid2", {31'd0, dec_valid2}, {31'd0, since >= 2});
        chk("dec_pc2", dec_pc2, since >= 2 ? R2 + 32'(4 * (since - 2)) : 32'h0);
      end
    end
    if (!r) begin
      mpc = 32'h0;
      qpc.delete();
      qins.delete();
      armed = 1'b1;
      clean2 = 1'b1;
      since = 1;
    end else begin
      if (rv || !rd) clean2 = 1'b0;
      since++;
      if (rv) begin
        mpc = {rp[31:2], 2'b00};
        qpc.delete();
        qins.delete();
      end else begin
        deq = qpc.size() != 0 && rd;
        enq = qpc.size() < 2 || deq;
        if (deq) begin
          void'(qpc.pop_front());
          void'(qins.pop_front());
        end
        if (enq) begin
          qpc.push_back(mpc);
          qins.push_back(word(mpc));
          mpc = mpc + 32'd4;
        end
      end
    end
  endtask

  initial begin
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 1);
    step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(1, 1, 32'h40, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1);
    step(1, 1, 32'h43, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(0, 1, 32'h80, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1);
    step(1, 1, 32'hFFFF_FFF4, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1);
    for (int i = 0; i < 300; i++)
      step($urandom_range(39) != 0, $urandom_range(7) == 0, $urandom, $urandom_range(3) != 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
